// File: rtl/hub75_scan_counter_if.sv
// HUB75 scan counter bus: control strobes in, line/frame flags and addresses out.
// Latency: n/a (wiring only).
// Backpressure: none; the strobes are levels/edges sampled every cycle.
// Ports (signals):
//   addColumns, rstColumns, addRow : control FSM -> counter
//   compColumns, compRows          : counter -> control FSM
//   o_row_addr, o_col, o_fb_addr   : counter -> panel / framebuffer
//   o_frame_start                  : counter -> frame sync consumers
interface hub75_scan_counter_if #(
    parameter int COL_W = 7,
    parameter int ROW_W = 4
);
    logic                     addColumns;
    logic                     rstColumns;
    logic                     addRow;
    logic                     compColumns;
    logic                     compRows;
    logic [ROW_W-1:0]         o_row_addr;
    logic [COL_W-1:0]         o_col;
    logic [ROW_W+COL_W-2:0]   o_fb_addr;
    logic                     o_frame_start;

    // Control FSM side
    modport master (
        output addColumns, rstColumns, addRow,
        input  compColumns, compRows, o_row_addr, o_col, o_fb_addr, o_frame_start
    );

    // Counter side
    modport slave (
        input  addColumns, rstColumns, addRow,
        output compColumns, compRows, o_row_addr, o_col, o_fb_addr, o_frame_start
    );
endinterface

// File: rtl/hub75_scan_counter.sv
// HUB75 column/row scan counter driving panel row address and framebuffer address.
// Latency: counters update 1 cycle after a strobe is sampled; fb address has no extra delay.
// Backpressure: none; column count saturates at COLS until cleared.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   bus    : slave modport of hub75_scan_counter_if (strobes in, flags/addresses out)
module hub75_scan_counter #(
    parameter int COLS      = 64,
    parameter int SCAN_ROWS = 16,
    parameter int COL_W     = 7,
    parameter int ROW_W     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    hub75_scan_counter_if.slave  bus
);
    localparam logic [COL_W-1:0] COLS_C   = COL_W'(COLS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SCAN_ROWS - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             add_row_q;
    logic             comp_rows_q, comp_rows_d;
    logic             frame_start_q, frame_start_d;
    logic             row_rise;
    logic             row_wrap;

    always_comb begin
        col_d         = col_q;
        row_d         = row_q;
        comp_rows_d   = comp_rows_q;
        frame_start_d = 1'b0;

        // Clear beats increment; increment stops at COLS (no wrap).
        if (bus.rstColumns) begin
            col_d = '0;
        end else if (bus.addColumns && (col_q < COLS_C)) begin
            col_d = col_q + COL_W'(1);
        end

        // A held addRow level advances the row only once.
        row_rise = bus.addRow & ~add_row_q;
        row_wrap = row_rise && (row_q == ROW_LAST);

        if (row_rise) begin
            row_d = row_wrap ? '0 : row_q + ROW_W'(1);
            // Sticky frame-complete flag: set by the wrap, dropped by the next
            // ordinary advance, so it stays up across the whole line-0 period.
            comp_rows_d = row_wrap;
        end
        frame_start_d = row_wrap;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q         <= '0;
            row_q         <= '0;
            add_row_q     <= 1'b0;
            comp_rows_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            add_row_q     <= bus.addRow;
            comp_rows_q   <= comp_rows_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.compColumns   = (col_q == COLS_C);
    assign bus.compRows      = comp_rows_q;
    assign bus.o_row_addr    = row_q;
    assign bus.o_col         = col_q;
    // At col == COLS the low bits alias to column 0; never consumed there.
    assign bus.o_fb_addr     = {row_q, col_q[COL_W-2:0]};
    assign bus.o_frame_start = frame_start_q;
endmodule

// File: tb/tb_hub75_scan_counter.sv
// Directed bench for hub75_scan_counter with a queued scoreboard.
// Latency: each stimulus step expects its result after the next rising edge.
// Backpressure: n/a.
module tb_hub75_scan_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hub75_scan_counter_if #(.COL_W(7), .ROW_W(4)) bus ();

    hub75_scan_counter #(
        .COLS(64), .SCAN_ROWS(16), .COL_W(7), .ROW_W(4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        int         cyc;
        logic [6:0] col;
        logic [3:0] row;
        logic       cc;
        logic       cr;
        logic       fs;
    } exp_t;

    exp_t q[$];

    // Model state tracked by the stimulus for the expected values.
    int   mcol = 0;
    int   mrow = 0;
    logic mcr  = 1'b0;

    // Monitor: compare every expectation due at this cycle, sampled on the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t       e;
            logic [9:0] efb;
            e   = q.pop_front();
            efb = {e.row, e.col[5:0]};
            n_cmp++;
            if (e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            end else if ({bus.o_col, bus.o_row_addr, bus.compColumns, bus.compRows, bus.o_frame_start, bus.o_fb_addr}
                         !== {e.col, e.row, e.cc, e.cr, e.fs, efb}) begin
                n_bad++;
                $display("FAIL %s @%0d: got col=%0d row=%0d cc=%b cr=%b fs=%b fb=%h, want col=%0d row=%0d cc=%b cr=%b fs=%b fb=%h",
                         e.name, cyc, bus.o_col, bus.o_row_addr, bus.compColumns, bus.compRows,
                         bus.o_frame_start, bus.o_fb_addr, e.col, e.row, e.cc, e.cr, e.fs, efb);
            end
        end
    end

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input string nm, input logic rs, input logic ac, input logic rc, input logic ar,
                        input int ecol, input int erow, input logic ecr, input logic efs);
        exp_t e;
        rst            = rs;
        bus.addColumns = ac;
        bus.rstColumns = rc;
        bus.addRow     = ar;
        e.name = nm;
        e.cyc  = cyc + 1;
        e.col  = 7'(ecol);
        e.row  = 4'(erow);
        e.cc   = (ecol == 64);
        e.cr   = ecr;
        e.fs   = efs;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One addRow pulse (high one cycle, then low one cycle).
    task automatic pulse_row(input string nm);
        logic wrap;
        wrap = (mrow == 15);
        mrow = wrap ? 0 : mrow + 1;
        mcr  = wrap;
        step(nm, 0, 0, 0, 1, mcol, mrow, mcr, wrap);
        step(nm, 0, 0, 0, 0, mcol, mrow, mcr, 1'b0);
    endtask

    initial begin
        bus.addColumns = 1'b0;
        bus.rstColumns = 1'b0;
        bus.addRow     = 1'b0;
        @(posedge clk);
        #1;

        // T1: random inputs, then a one-cycle reset with inputs still active
        for (int i = 0; i < 6; i++) begin
            bus.addColumns = 1'($urandom_range(0, 1));
            bus.rstColumns = 1'($urandom_range(0, 1));
            bus.addRow     = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        step("t1_reset", 1, 1, 0, 1, 0, 0, 0, 0);
        step("t1_idle",  0, 0, 0, 0, 0, 0, 0, 0);

        // T2: line fill, fb address tracks the column, then saturation
        for (int i = 1; i <= 64; i++) begin
            mcol = i;
            step("t2_fill", 0, 1, 0, 0, mcol, 0, 0, 0);
        end
        for (int i = 0; i < 10; i++) step("t2_sat", 0, 1, 0, 0, 64, 0, 0, 0);
        step("t2_hold", 0, 0, 0, 0, 64, 0, 0, 0);

        // T3: clear wins over add
        mcol = 0;
        step("t3_clear", 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 30; i++) begin
            mcol = i;
            step("t3_fill", 0, 1, 0, 0, mcol, 0, 0, 0);
        end
        mcol = 0;
        step("t3_prio", 0, 1, 1, 0, 0, 0, 0, 0);

        // T4: held addRow advances once (3 -> 4)
        for (int i = 0; i < 3; i++) pulse_row("t4_pre");
        mrow = 4;
        for (int i = 0; i < 5; i++) step("t4_hold", 0, 0, 0, 1, 0, 4, 0, 0);
        step("t4_rel", 0, 0, 0, 0, 0, 4, 0, 0);

        // T5: reach row 0 by wrap, then 16 pulses wrap again, 17th clears compRows
        while (mrow != 0) pulse_row("t5_to0");
        for (int i = 1; i <= 17; i++) pulse_row("t5_frame");

        // Simultaneous clear+add+row rise: both counters update together
        for (int i = 1; i <= 5; i++) begin
            mcol = i;
            step("sim_fill", 0, 1, 0, 0, mcol, mrow, mcr, 0);
        end
        mcol = 0;
        mrow = mrow + 1;
        mcr  = 1'b0;
        step("sim_both", 0, 1, 1, 1, 0, mrow, 0, 0);
        mcol = 1;
        step("sim_level", 0, 1, 0, 1, 1, mrow, 0, 0);
        step("sim_rel",   0, 0, 0, 0, 1, mrow, 0, 0);

        // T6: mid-frame reset at row 9 col 40, then a normal frame
        for (int i = 2; i <= 40; i++) begin
            mcol = i;
            step("t6_fill", 0, 1, 0, 0, mcol, mrow, mcr, 0);
        end
        while (mrow != 9) pulse_row("t6_row");
        step("t6_chk", 0, 0, 0, 0, 40, 9, 0, 0);
        mcol = 0;
        mrow = 0;
        mcr  = 1'b0;
        step("t6_reset", 1, 1, 0, 1, 0, 0, 0, 0);
        step("t6_after", 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) pulse_row("t6_frame");

        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
